// File: rtl/stream_arbiter.sv
// Round-robin N-way valid/ready arbiter feeding one registered output beat.
// Define STREAM_ARBITER_LOCK_EN to add in_last and hold the grant for whole packets.
module stream_arbiter #(
   parameter int DW = 8,
   parameter int N  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic [N*DW-1:0] in_data,
`ifdef STREAM_ARBITER_LOCK_EN
   input  logic [N-1:0]    in_last,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [N-1:0]    out_sel
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

   logic [PW-1:0] ptr;
   logic [PW-1:0] grant_idx;
   logic [PW-1:0] next_ptr;
   logic [N-1:0]  grant;
   logic [DW-1:0] sel_data;
   logic          load;
   logic          any_grant;

`ifdef STREAM_ARBITER_LOCK_EN
   logic          locked;
   logic [PW-1:0] lock_idx;
`endif

   assign load      = !out_valid || out_ready;
   assign any_grant = |grant;
   // Reset masks in_ready so no requester sees a handshake that will be discarded.
   assign in_ready  = grant & {N{load && !rst}};
   assign next_ptr  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!(|grant) && in_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
         end
      end
`ifdef STREAM_ARBITER_LOCK_EN
      if (locked) begin
         grant     = '0;
         grant_idx = lock_idx;
         if (in_valid[lock_idx]) grant[lock_idx] = 1'b1;
      end
`endif
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         sel_data = sel_data | ({DW{grant[i]}} & in_data[i*DW +: DW]);
      end
   end

   // Output stage: loads on an empty or draining register, holds on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
`ifdef STREAM_ARBITER_LOCK_EN
         locked    <= 1'b0;
         lock_idx  <= '0;
`endif
      end else if (load) begin
         if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant;
`ifdef STREAM_ARBITER_LOCK_EN
            locked    <= !in_last[grant_idx];
            lock_idx  <= grant_idx;
            if (in_last[grant_idx]) ptr <= next_ptr;
`else
            ptr       <= next_ptr;
`endif
         end else begin
            out_valid <= 1'b0;
            out_sel   <= '0;
         end
      end
   end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Round-robin arbiter that shares one DW-bit output stream between N valid/ready requesters.
- Produces a one-hot grant and uses it to select the winning requester's data through a one-hot AND-OR select.
- Registers the selected beat into a single-entry output stage.
- Sits in front of any shared downstream resource (bus, FIFO, ALU port) that accepts one beat per cycle.

Parameters:
- DW, 8, data width per requester in bits.
- N, 4, number of requesters; legal range N >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  bit i: requester i has a beat on its slice of in_data.
- in_ready  output  N  bit i: requester i's beat is accepted this cycle.
- in_data  input  N*DW  requester i data at bits [(i+1)*DW-1 -: DW].
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_data  output  DW  registered selected beat.
- out_sel  output  N  registered one-hot grant that produced out_data; 0 when out_valid=0.

Behaviour:
- Reset (rst=1 at the edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0.
  - Lock state cleared (feature only).
  - rst overrides any handshake in the same cycle; a beat held mid-transfer is dropped.
- load = !out_valid | out_ready (output stage empty or draining this cycle).
- Grant (combinational): grant = one-hot of the first i with in_valid[i]=1, searching ptr, ptr+1, ... mod N. grant=0 if no in_valid.
- in_ready = grant & {N{load}}. At most one in_ready bit is high. in_ready never depends on in_valid of another requester beyond the priority search.
- Edge update when load=1 and grant!=0:
  - out_data <= OR over i of ({DW{grant[i]}} & slice i).
  - out_sel <= grant; out_valid <= 1.
  - ptr <= (index(grant)+1) mod N; wrap from N-1 to 0.
- Edge update when load=1 and grant=0: out_valid <= 0, out_sel <= 0. out_data holds its value; it is don't-care and not checked.
- Edge update when load=0 (stall: out_valid=1, out_ready=0): out_data, out_sel, out_valid and ptr all hold; in_ready=0.
- Latency: 1 cycle from input handshake to out_valid.
- Full throughput: a new beat is accepted every cycle while out_ready=1.
- Simultaneous drain and fill: same cycle, no bubble.
- Fairness: with all N requesters continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... Every requester is served within N accepted beats.
- A requester may drop in_valid before being granted; no state is affected.

Optional Feature:
- Macro: STREAM_ARBITER_LOCK_EN.
- Defined:
  - Adds port in_last (input, N bits; bit i marks the final beat of requester i's packet).
  - Once requester g is granted a beat with in_last[g]=0, a lock bit is set. While locked, grant = one-hot(g) if in_valid[g], else 0; other requesters wait even when valid.
  - Lock clears on acceptance of g's beat with in_last[g]=1.
  - ptr advances only on that last-beat acceptance.
  - Reset clears the lock.
- Undefined: no in_last port; arbitration is per beat as described above.

Test Plan (N=4, DW=8):
- Reset: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_sel=0, in_ready=0 while rst=1. First grant after release is requester 0.
- All requesters valid (data 0xA0,0xA1,0xA2,0xA3), out_ready=1 for 8 cycles -> out_data 0xA0,0xA1,0xA2,0xA3,0xA0,... each 1 cycle after its accept; out_sel 0001,0010,0100,1000,0001.
- Backpressure: out_valid=1 with 0xA1, hold out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000 and out_data stays 0xA1. Release -> 0xA1 consumed and 0xA2 loaded in the same cycle.
- Wrap/skip: ptr=3, only in_valid[1] set with data 0x55 -> in_ready=0010, out_data=0x55, out_sel=0010, then ptr=2.
- Idle drain: single beat 0x7E from requester 2, then in_valid=0 with out_ready=1 -> out_valid=1 for exactly one cycle, then 0 with out_sel=0.
- Lock (STREAM_ARBITER_LOCK_EN): requester 1 sends 3 beats with in_last=0,0,1 while requester 0 stays valid -> requester 0 is granted only after requester 1's last beat. With the macro undefined, the same stimulus interleaves requesters 1 and 0 (1,0,1,0,1).
